// File: rtl/bus_load_regs.sv
// Destination end of the common bus: AR, PC, DR, AC, IR, a small RAM and the
// sequence counter whose one-hot decode provides timing signals T0..T(2**SCW-1).
module bus_load_regs #(
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int SCW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     bus,
  input  logic              ar_ld,
  input  logic              ar_inr,
  input  logic              ar_clr,
  input  logic              pc_ld,
  input  logic              pc_inr,
  input  logic              pc_clr,
  input  logic              dr_ld,
  input  logic              ac_ld,
  input  logic              ac_clr,
  input  logic              ir_ld,
  input  logic              mem_wr,
  input  logic              sc_inr,
  input  logic              sc_clr,
  output logic [AW-1:0]     ar,
  output logic [AW-1:0]     pc,
  output logic [DW-1:0]     dr,
  output logic [DW-1:0]     ac,
  output logic [DW-1:0]     ir,
  output logic [DW-1:0]     mem_rd,
  output logic [2**SCW-1:0] t
);

  logic [DW-1:0]  mem [2**AW];
  logic [SCW-1:0] sc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ar <= '0;
      pc <= '0;
      dr <= '0;
      ac <= '0;
      ir <= '0;
      sc <= '0;
    end else begin
      // Clear beats load beats increment on every register.
      if (ar_clr)      ar <= '0;
      else if (ar_ld)  ar <= bus[AW-1:0];
      else if (ar_inr) ar <= ar + 1'b1;

      if (pc_clr)      pc <= '0;
      else if (pc_ld)  pc <= bus[AW-1:0];
      else if (pc_inr) pc <= pc + 1'b1;

      if (dr_ld) dr <= bus;

      if (ac_clr)     ac <= '0;
      else if (ac_ld) ac <= bus;

      if (ir_ld) ir <= bus;

      if (sc_clr)      sc <= '0;
      else if (sc_inr) sc <= sc + 1'b1;
    end
  end

  // Memory is not reset; the address is the AR value before this edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) mem[ar] <= bus;
  end

  always_comb begin
    mem_rd = mem[ar];
  end

  always_comb begin
    t     = '0;
    t[sc] = 1'b1;
  end

endmodule
